// File: rtl/fa_serial_handshake_if.sv
// Start/done handshake bundle between an operand source and the serial adder.
// The master drives the request and operands; the slave returns status and result.
interface fa_serial_handshake_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/fa_serial_handshake.sv
// Bit-serial WIDTH-bit adder: {cout, sum} = a + b + cin, LSB first, one bit per clock
// through a single carry flop, framed by a start/done handshake.
module fa_serial_handshake #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fa_serial_handshake_if.slave  bus_if
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sum_bit;
    logic               carry_bit;

    // Full-adder cell on the current operand LSBs and the stored carry
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
        carry_bit = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    a_d     = bus_if.a;
                    b_d     = bus_if.b;
                    c_d     = bus_if.cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New sum bit enters at the MSB so the result lands LSB-aligned after WIDTH shifts
                acc_d = (acc_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = acc_d;
                    cout_d  = carry_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;
    assign bus_if.sum  = sum_q;
    assign bus_if.cout = cout_q;

endmodule

// File: tb/tb_fa_serial_handshake.sv
// Directed bench for fa_serial_handshake at WIDTH=4, plus WIDTH=1 and WIDTH=8 instances.
module tb_fa_serial_handshake;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fa_serial_handshake_if #(.WIDTH(4)) if4 ();
    fa_serial_handshake_if #(.WIDTH(1)) if1 ();
    fa_serial_handshake_if #(.WIDTH(8)) if8 ();

    fa_serial_handshake #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus_if(if4));
    fa_serial_handshake #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus_if(if1));
    fa_serial_handshake #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus_if(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out4(input string tag, input logic bsy, input logic dn,
                            input logic [3:0] s, input logic co);
        chk({tag, " busy"}, 32'(if4.busy), 32'(bsy));
        chk({tag, " done"}, 32'(if4.done), 32'(dn));
        chk({tag, " sum"},  32'(if4.sum),  32'(s));
        chk({tag, " cout"}, 32'(if4.cout), 32'(co));
    endtask

    // One WIDTH=4 operation started at the current negedge, checked cycle by cycle to k+6.
    // poke re-pulses start at k+2 and scrambles the operands while the op is in flight.
    task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic cv, input logic [3:0] es, input logic ec,
                       input logic [3:0] ps, input logic pc, input bit poke);
        if4.start = 1'b1;
        if4.a     = av;
        if4.b     = bv;
        if4.cin   = cv;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) if4.start = 1'b0;
            if (poke && i == 2) begin
                if4.start = 1'b1;
                if4.a     = 4'h1;
                if4.b     = 4'h1;
                if4.cin   = ~cv;
            end
            if (poke && i == 3) begin
                if4.start = 1'b0;
                if4.a     = ~av;
                if4.b     = ~bv;
            end
            chk_out4($sformatf("%s c%0d", tag, i), (i <= 4), (i == 5),
                     (i >= 5) ? es : ps, (i >= 5) ? ec : pc);
        end
    endtask

    logic [3:0] ha [3];
    logic [3:0] hb [3];
    logic       hc [3];
    logic [3:0] hs [3];
    logic       hco[3];

    initial begin
        int         cyc;
        int         idx;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       ec;
        logic [7:0] wa;
        logic [7:0] wb;
        logic       wc;
        logic [8:0] w9;
        logic [4:0] r5;
        logic [8:0] n9;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        {if4.start, if4.a, if4.b, if4.cin} = '0;
        {if1.start, if1.a, if1.b, if1.cin} = '0;
        {if8.start, if8.a, if8.b, if8.cin} = '0;

        // Asynchronous reset between edges
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_out4("async_rst", 1'b0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_out4($sformatf("idle%0d", i), 1'b0, 1'b0, 4'h0, 1'b0);
        end

        op4("basic",  4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0);
        op4("carry1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 4'h8, 1'b0, 1'b0);
        op4("carry2", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        op4("carry3", 4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0);
        op4("ignore", 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 4'h1, 1'b0, 1'b1);
        op4("midchg", 4'h6, 4'h9, 1'b1, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1);

        // start held high: done every 6 cycles, operands refreshed in each idle cycle
        ha[0] = 4'h2; hb[0] = 4'h3; hc[0] = 1'b0; hs[0] = 4'h5; hco[0] = 1'b0;
        ha[1] = 4'h9; hb[1] = 4'h8; hc[1] = 1'b0; hs[1] = 4'h1; hco[1] = 1'b1;
        ha[2] = 4'h4; hb[2] = 4'h4; hc[2] = 1'b1; hs[2] = 4'h9; hco[2] = 1'b0;
        if4.start = 1'b1;
        if4.a = ha[0]; if4.b = hb[0]; if4.cin = hc[0];
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            idx = (i + 1) / 6 - 1;
            chk_out4($sformatf("hold c%0d", i), ((i % 6) >= 1 && (i % 6) <= 4), ((i % 6) == 5),
                     (idx < 0) ? 4'h0 : hs[idx], (idx < 0) ? 1'b1 : hco[idx]);
            if (i == 6 || i == 12) begin
                if4.a = ha[i / 6]; if4.b = hb[i / 6]; if4.cin = hc[i / 6];
            end
            if (i == 17) if4.start = 1'b0;
        end

        // Reset mid-operation discards the op and never produces done
        if4.start = 1'b1; if4.a = 4'h7; if4.b = 4'h7; if4.cin = 1'b0;
        @(negedge clk);
        if4.start = 1'b0;
        chk("midrst busy k+1", 32'(if4.busy), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_out4("midrst", 1'b0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_out4($sformatf("postrst idle%0d", i), 1'b0, 1'b0, 4'h0, 1'b0);
        end
        op4("postrst", 4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0);

        // All 512 WIDTH=4 operand combinations back to back
        if4.start = 1'b1;
        for (int n = 0; n < 512; n++) begin
            n9 = 9'(n);
            ea = n9[8:5]; eb = n9[4:1]; ec = n9[0];
            if4.a = ea; if4.b = eb; if4.cin = ec;
            r5 = 5'(ea) + 5'(eb) + 5'(ec);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!if4.done && cyc < 20);
            chk($sformatf("exh4 lat n=%0d", n), 32'(cyc), 32'd5);
            chk($sformatf("exh4 res n=%0d", n), 32'({if4.cout, if4.sum}), 32'(r5));
            @(negedge clk);
            chk($sformatf("exh4 gap n=%0d", n), 32'({if4.busy, if4.done}), 32'd0);
        end
        if4.start = 1'b0;

        // WIDTH=1: every combination, busy one cycle, done at k+2
        if1.start = 1'b1;
        for (int n = 0; n < 8; n++) begin
            n9 = 9'(n);
            if1.a = n9[2:2]; if1.b = n9[1:1]; if1.cin = n9[0];
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) chk($sformatf("w1 busy n=%0d", n), 32'(if1.busy), 32'd1);
            end while (!if1.done && cyc < 20);
            chk($sformatf("w1 lat n=%0d", n), 32'(cyc), 32'd2);
            chk($sformatf("w1 res n=%0d", n), 32'({if1.cout, if1.sum}),
                32'(n9[2]) + 32'(n9[1]) + 32'(n9[0]));
            @(negedge clk);
            chk($sformatf("w1 gap n=%0d", n), 32'({if1.busy, if1.done}), 32'd0);
        end
        if1.start = 1'b0;

        // WIDTH=8: corner vectors then random ones
        if8.start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
                wa = 8'hFF; wb = 8'hFF; wc = 1'b1;
            end else if (n == 1) begin
                wa = 8'h00; wb = 8'h00; wc = 1'b0;
            end else begin
                wa = 8'($urandom_range(0, 255));
                wb = 8'($urandom_range(0, 255));
                wc = 1'($urandom_range(0, 1));
            end
            if8.a = wa; if8.b = wb; if8.cin = wc;
            w9 = 9'(wa) + 9'(wb) + 9'(wc);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!if8.done && cyc < 30);
            chk($sformatf("w8 lat n=%0d", n), 32'(cyc), 32'd9);
            chk($sformatf("w8 res n=%0d a=%0h b=%0h c=%0d", n, wa, wb, wc),
                32'({if8.cout, if8.sum}), 32'(w9));
            @(negedge clk);
            chk($sformatf("w8 gap n=%0d", n), 32'({if8.busy, if8.done}), 32'd0);
        end
        if8.start = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
